// File: rtl/noc_pkg.sv
// Shared NoC definitions: address layout, flit identifiers, header field offsets, injector states.
package noc_pkg;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned ADDR_XY_W  = 2;
  localparam int unsigned ADDR_X_LSB = 0;
  localparam int unsigned ADDR_Y_LSB = 2;

  localparam int unsigned FLIT_ID_W = 3;
  localparam logic [FLIT_ID_W-1:0] FLIT_IDLE    = 3'b000;
  localparam logic [FLIT_ID_W-1:0] FLIT_HEADER  = 3'b001;
  localparam logic [FLIT_ID_W-1:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [FLIT_ID_W-1:0] FLIT_TAIL    = 3'b100;

  // Header flit layout: {zeros, len, src, dst}
  localparam int unsigned HDR_DST_LSB = 0;
  localparam int unsigned HDR_SRC_LSB = 4;
  localparam int unsigned HDR_LEN_LSB = 8;

  typedef struct packed {
    logic [ADDR_XY_W-1:0] y;
    logic [ADDR_XY_W-1:0] x;
  } noc_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_TAIL
  } inj_state_t;

endpackage

// File: rtl/noc_credit_counter.sv
// Saturating credit counter: +1 on inc, -1 on dec, overflow flagged when inc arrives at MAX.
module noc_credit_counter #(
  parameter int unsigned MAX   = 4,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf_c
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  logic inc_ok_c;
  logic dec_ok_c;

  // An increment at full count is a protocol error and is dropped
  assign ovf_c    = inc && (count == MAX_V);
  assign inc_ok_c = inc && !ovf_c;
  assign dec_ok_c = dec && (count != '0);

  // Count register; coincident inc and dec cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= MAX_V;
    end else if (inc_ok_c && !dec_ok_c) begin
      count <= count + 1'b1;
    end else if (dec_ok_c && !inc_ok_c) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/noc_flit_injector.sv
// Network-interface transmitter: packet request + data words -> HEADER/PAYLOAD/TAIL flits, credit flow control.
module noc_flit_injector
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CREDITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              cur_addr,
  input  logic                           pkt_valid,
  output logic                           pkt_ready,
  input  logic [ADDR_W-1:0]              pkt_dst,
  input  logic [LEN_W-1:0]               pkt_len,
  input  logic                           data_valid,
  output logic                           data_ready,
  input  logic [DATA_W-1:0]              data_in,
  output logic                           flit_valid,
  output logic [FLIT_ID_W-1:0]           flit_id,
  output logic [ADDR_W-1:0]              dst_addr,
  output logic [DATA_W-1:0]              flit_data,
  input  logic                           credit_in,
  output logic [$clog2(CREDITS+1)-1:0]   credits_avail,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned CNT_W = $clog2(CREDITS + 1);

  inj_state_t             state, state_d;
  logic [LEN_W-1:0]       rem, rem_d;
  logic [ADDR_W-1:0]      dst_d;
  logic                   flit_valid_d;
  logic [FLIT_ID_W-1:0]   flit_id_d;
  logic [DATA_W-1:0]      flit_data_d;
  logic [DATA_W-1:0]      hdr_c;
  logic                   pkt_ready_d;
  logic                   busy_d;
  logic                   err_d;
  logic                   send_c;
  logic                   cnt_ovf_c;
  logic                   has_credit_c;
  logic                   data_hs_c;
  logic                   accept_c;

  noc_credit_counter #(
    .MAX   (CREDITS),
    .CNT_W (CNT_W)
  ) u_credits (
    .clk   (clk),
    .rst   (rst),
    .inc   (credit_in),
    .dec   (send_c),
    .count (credits_avail),
    .ovf_c (cnt_ovf_c)
  );

  assign has_credit_c = (credits_avail != '0);
  assign data_ready   = ((state == ST_BODY) || (state == ST_TAIL)) && has_credit_c;
  assign data_hs_c    = data_valid && data_ready;
  assign accept_c     = (state == ST_IDLE) && pkt_valid && pkt_ready;

  // Header flit image; rem still holds the full packet length while in HEAD
  always_comb begin
    hdr_c = '0;
    hdr_c[HDR_DST_LSB +: ADDR_W] = dst_addr;
    hdr_c[HDR_SRC_LSB +: ADDR_W] = cur_addr;
    hdr_c[HDR_LEN_LSB +: LEN_W]  = rem;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state;
    rem_d        = rem;
    dst_d        = dst_addr;
    flit_valid_d = 1'b0;
    flit_id_d    = FLIT_IDLE;
    flit_data_d  = '0;
    err_d        = cnt_ovf_c;
    send_c       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (pkt_len == '0) begin
            err_d = 1'b1;
          end else begin
            dst_d   = pkt_dst;
            rem_d   = pkt_len;
            state_d = ST_HEAD;
          end
        end
      end
      ST_HEAD: begin
        if (has_credit_c) begin
          send_c       = 1'b1;
          flit_valid_d = 1'b1;
          flit_id_d    = FLIT_HEADER;
          flit_data_d  = hdr_c;
          state_d      = (rem > LEN_W'(1)) ? ST_BODY : ST_TAIL;
        end
      end
      ST_BODY: begin
        if (data_hs_c) begin
          send_c       = 1'b1;
          flit_valid_d = 1'b1;
          flit_id_d    = FLIT_PAYLOAD;
          flit_data_d  = data_in;
          rem_d        = rem - 1'b1;
          if (rem_d == LEN_W'(1)) begin
            state_d = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (data_hs_c) begin
          send_c       = 1'b1;
          flit_valid_d = 1'b1;
          flit_id_d    = FLIT_TAIL;
          flit_data_d  = data_in;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pkt_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any packet in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rem        <= '0;
      dst_addr   <= '0;
      flit_valid <= 1'b0;
      flit_id    <= FLIT_IDLE;
      flit_data  <= '0;
      pkt_ready  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      rem        <= rem_d;
      dst_addr   <= dst_d;
      flit_valid <= flit_valid_d;
      flit_id    <= flit_id_d;
      flit_data  <= flit_data_d;
      pkt_ready  <= pkt_ready_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_noc_flit_injector.sv
// Scoreboard bench for noc_flit_injector (DATA_W=32, LEN_W=4, CREDITS=4, cur_addr=5).
module tb_noc_flit_injector;
  import noc_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned CW     = 3;

  typedef struct {
    logic [2:0]        id;
    logic [3:0]        dst;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        cur_addr;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [3:0]        pkt_dst;
  logic [LEN_W-1:0]  pkt_len;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_in;
  logic              flit_valid;
  logic [2:0]        flit_id;
  logic [3:0]        dst_addr;
  logic [DATA_W-1:0] flit_data;
  logic              credit_in;
  logic [CW-1:0]     credits_avail;
  logic              busy;
  logic              err;

  logic credit_pulse;
  logic echo_en;
  logic abort;
  int   total;
  int   bad;
  int   n_flits;
  int   cyc;
  int   last_cyc;
  exp_t sb[$];

  noc_flit_injector #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CREDITS(4)) dut (
    .clk(clk), .rst(rst), .cur_addr(cur_addr),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_valid(flit_valid), .flit_id(flit_id), .dst_addr(dst_addr), .flit_data(flit_data),
    .credit_in(credit_in), .credits_avail(credits_avail), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Router stand-in: either echoes a credit for every flit it sees, or takes manual pulses
  assign credit_in = (echo_en & flit_valid) | credit_pulse;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (flit_valid) begin
        n_flits++;
        if (sb.size() == 0) begin
          chk("unexpected_flit", 64'(flit_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("flit_id", 64'(flit_id), 64'(e.id));
          chk("flit_data", 64'(flit_data), 64'(e.data));
          chk("flit_dst", 64'(dst_addr), 64'(e.dst));
          if (echo_en) begin
            chk("cred_coincident", 64'(credits_avail), 64'(3));
            if (e.id != FLIT_HEADER) chk("flit_gap", 64'(cyc - last_cyc), 64'(1));
          end
        end
        last_cyc = cyc;
      end else begin
        chk("idle_id", 64'(flit_id), 64'(FLIT_IDLE));
      end
    end
  endtask

  // Push expected flits, then drive the request and the data words
  task automatic send_pkt(input logic [3:0] dst, input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] d0);
    int   t;
    exp_t e;
    if (len != 0) begin
      e.id = FLIT_HEADER; e.dst = dst;
      e.data = (DATA_W'(len) << 8) | (DATA_W'(cur_addr) << 4) | DATA_W'(dst);
      sb.push_back(e);
      for (int i = 0; i < int'(len); i++) begin
        e.id   = (i == int'(len) - 1) ? FLIT_TAIL : FLIT_PAYLOAD;
        e.data = d0 + DATA_W'(i);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    pkt_valid = 1'b1; pkt_dst = dst; pkt_len = len;
    t = 0;
    while (!pkt_ready && t < 50) begin @(negedge clk); t++; end
    chk("req_accept", 64'(t < 50), 64'(1));
    @(negedge clk);
    pkt_valid = 1'b0; pkt_dst = 4'hF; pkt_len = '1;
    for (int i = 0; i < int'(len); i++) begin
      if (abort) break;
      data_valid = 1'b1; data_in = d0 + DATA_W'(i);
      t = 0;
      while (!data_ready && !abort && t < 200) begin @(negedge clk); t++; end
      if (abort) break;
      chk("data_accept", 64'(t < 200), 64'(1));
      @(negedge clk);
    end
    data_valid = 1'b0; data_in = '0;
  endtask

  task automatic wait_flits(input string tag, input int target);
    int t = 0;
    while (n_flits < target && t < 200) begin @(negedge clk); #1; t++; end
    chk(tag, 64'(n_flits >= target), 64'(1));
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int base;
    total = 0; bad = 0; n_flits = 0; cyc = 0; last_cyc = 0;
    rst = 1'b1; cur_addr = 4'h5;
    pkt_valid = 1'b0; pkt_dst = '0; pkt_len = '0;
    data_valid = 1'b0; data_in = '0;
    credit_pulse = 1'b0; echo_en = 1'b0; abort = 1'b0;
    fork monitor(); join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_flit_valid", 64'(flit_valid), 64'(0));
    chk("rst_flit_id", 64'(flit_id), 64'(FLIT_IDLE));
    chk("rst_credits", 64'(credits_avail), 64'(4));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pkt_ready", 64'(pkt_ready), 64'(0));
    chk("rst_data_ready", 64'(data_ready), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_pkt_ready", 64'(pkt_ready), 64'(1));

    // Single-word packet: HEADER 0x015A then TAIL
    send_pkt(4'hA, 4'd1, 32'hDEADBEEF);
    wait_drain("drain_single");
    chk("single_credits", 64'(credits_avail), 64'(2));

    // Starvation: 2 credits left, 5-word packet, credits returned one by one
    base = n_flits;
    fork
      send_pkt(4'h3, 4'd5, 32'h100);
      begin
        wait_flits("starve_first2", base + 2);
        repeat (3) @(negedge clk);
        chk("starve_flits", 64'(n_flits), 64'(base + 2));
        chk("starve_ready", 64'(data_ready), 64'(0));
        chk("starve_credits", 64'(credits_avail), 64'(0));
        chk("starve_busy", 64'(busy), 64'(1));
        for (int k = 0; k < 4; k++) begin
          credit_pulse = 1'b1;
          @(negedge clk);
          credit_pulse = 1'b0;
          repeat (4) @(negedge clk);
          chk("starve_release", 64'(n_flits), 64'(base + 3 + k));
        end
      end
    join
    wait_drain("drain_starve");
    chk("starve_end_credits", 64'(credits_avail), 64'(0));
    credit_pulse = 1'b1;
    repeat (4) @(negedge clk);
    credit_pulse = 1'b0;
    chk("refill_credits", 64'(credits_avail), 64'(4));
    chk("refill_err", 64'(err), 64'(0));

    // Credit return at full count: one-cycle err, count held
    credit_pulse = 1'b1;
    @(negedge clk);
    credit_pulse = 1'b0;
    chk("ovf_err", 64'(err), 64'(1));
    chk("ovf_credits", 64'(credits_avail), 64'(4));
    @(negedge clk);
    chk("ovf_err_clear", 64'(err), 64'(0));

    // 4-word packet, credits echoed back: back-to-back flits, count steady at 3
    echo_en = 1'b1;
    send_pkt(4'hC, 4'd4, 32'h1);
    wait_drain("drain_four");
    repeat (2) @(negedge clk);
    echo_en = 1'b0;
    chk("four_credits", 64'(credits_avail), 64'(4));

    // Zero-length request: accepted, err pulse, no flits
    base = n_flits;
    send_pkt(4'h7, 4'd0, 32'h0);
    chk("len0_err", 64'(err), 64'(1));
    chk("len0_busy", 64'(busy), 64'(0));
    chk("len0_ready", 64'(pkt_ready), 64'(1));
    @(negedge clk);
    chk("len0_err_clear", 64'(err), 64'(0));
    repeat (3) @(negedge clk);
    chk("len0_noflit", 64'(n_flits), 64'(base));

    // Async reset mid-BODY
    base = n_flits;
    fork
      send_pkt(4'h6, 4'd4, 32'h200);
      begin
        wait_flits("rst_body_wait", base + 2);
        #2;
        abort = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_flit_valid", 64'(flit_valid), 64'(0));
        chk("arst_flit_id", 64'(flit_id), 64'(FLIT_IDLE));
        chk("arst_flit_data", 64'(flit_data), 64'(0));
        chk("arst_dst", 64'(dst_addr), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_credits", 64'(credits_avail), 64'(4));
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("arst_no_tail", 64'(n_flits), 64'(base + 2));
    chk("arst_pkt_ready", 64'(pkt_ready), 64'(1));

    // Next packet after reset, self-addressed
    send_pkt(4'h5, 4'd2, 32'h300);
    wait_drain("drain_post_rst");
    repeat (2) @(negedge clk);
    chk("post_credits", 64'(credits_avail), 64'(1));
    chk("post_busy", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_flit_injector.md
Name: noc_flit_injector

Overview:
- Network-interface transmitter: converts a local packet request plus a stream of data words into the HEADER/PAYLOAD/TAIL flit sequence that a router input port consumes.
- Sits between a tile core and the router's Local input FIFO. It drives `flit_id` and `dst_addr` exactly as the port's LBDR route-compute stage expects.
- Flow control toward the router is credit-based, one credit per FIFO slot.

Parameters:
- DATA_W, 32, flit payload width in bits.
- LEN_W, 4, width of the packet length field; maximum packet is 2**LEN_W-1 data words.
- CREDITS, 4, router input FIFO depth and the credit counter's reset value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cur_addr  in  4  own tile address {y[1:0],x[1:0]}; static while not in reset.
- pkt_valid  in  1  packet request valid.
- pkt_ready  out  1  request accepted when pkt_valid & pkt_ready.
- pkt_dst  in  4  destination address {y,x}.
- pkt_len  in  LEN_W  number of data words in the packet.
- data_valid  in  1  data word valid.
- data_ready  out  1  data word consumed when data_valid & data_ready.
- data_in  in  DATA_W  data word.
- flit_valid  out  1  a flit is presented this cycle (one cycle per flit).
- flit_id  out  3  HEADER, PAYLOAD, TAIL or IDLE.
- dst_addr  out  4  destination of the current packet; held for all flits of the packet.
- flit_data  out  DATA_W  flit payload.
- credit_in  in  1  one-cycle pulse: the router freed one FIFO slot.
- credits_avail  out  clog2(CREDITS+1)  current credit count.
- busy  out  1  high in every state other than IDLE.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, credits=CREDITS, and every other output is 0 (flit_id=IDLE). Reset mid-packet abandons the packet; no TAIL flit is sent.
- All flit outputs are registered. flit_valid is a single-cycle pulse per flit, and flit_id=IDLE whenever flit_valid=0.
- Credits:
  - Decrement on every flit sent; increment on credit_in.
  - Send and credit_in in the same cycle leave the count unchanged.
  - credit_in while the count is CREDITS is ignored and pulses err.
  - No flit is sent while the count is 0.
- FSM states: IDLE, HEAD, BODY, TAIL.
- IDLE:
  - pkt_ready=1. On accept, latch pkt_dst into dst_addr and pkt_len into the remaining-word counter `rem`.
  - pkt_len=0: request is accepted and discarded, err pulses, state stays IDLE.
  - Otherwise go to HEAD.
- HEAD:
  - When credits>0, send a HEADER flit: flit_data[3:0]=dst, [7:4]=cur_addr, [7+LEN_W:8]=len, remaining bits 0.
  - Next state is BODY if len>1, else TAIL.
  - A header is sent no earlier than the cycle after request accept (1-cycle latency when credits are available).
- BODY:
  - data_ready = credits>0 (combinational). On a data handshake, send PAYLOAD carrying data_in in the next cycle and decrement rem.
  - When rem reaches 1, go to TAIL.
- TAIL:
  - data_ready = credits>0. On a handshake, send TAIL carrying data_in, then go to IDLE.
  - pkt_ready stays 0 until IDLE is reached; there is no back-to-back overlap of packets.
- data_ready=0 in IDLE and HEAD. data_valid in those states is ignored and no data is consumed.
- Self-addressed packets (pkt_dst==cur_addr) are sent normally; the router's Lport routes them back.
- pkt_dst, pkt_len and data_in are sampled only on their handshakes.
- Packet flit count = len+1: header, len-1 payload flits, tail.

Decomposition:
- Shared package `noc_pkg` holds:
  - flit_id constants: IDLE=3'b000, HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100.
  - Header field offsets.
  - Address width 4 and the x/y slice positions.
- One natural sub-module: `noc_credit_counter` (saturating up/down counter with overflow error), reused later by the router output side.

Test Plan:
- Single-word packet: cur_addr=5, CREDITS=4, pkt_dst=4'hA, pkt_len=1, data=32'hDEADBEEF. Expect exactly two flits: HEADER with flit_data[15:0]=16'h015A, then TAIL with 32'hDEADBEEF; credits 4→2; dst_addr=A on both flits.
- 4-word packet with no back-pressure, data 1..4. Expect HEADER, PAYLOAD(1), PAYLOAD(2), PAYLOAD(3), TAIL(4) on consecutive cycles; credits reach 0 only if no credit_in arrives.
- Credit starvation: CREDITS=2, pkt_len=5, credit_in held low.
  - Expect HEADER and PAYLOAD(1), then data_ready=0 and no flits.
  - Each subsequent credit_in pulse releases exactly one further flit, until TAIL.
- Simultaneous events:
  - credit_in coincident with a send: credits_avail unchanged.
  - credit_in at credits=CREDITS: err pulses for 1 cycle and the count stays CREDITS.
- pkt_len=0 request: pkt_ready=1, err pulse, no flit_valid, busy stays 0.
- Asynchronous reset asserted mid-BODY, away from a clock edge: outputs clear immediately, credits=CREDITS, no TAIL sent. The next packet after reset is emitted correctly, starting with HEADER.
